eei_initiator: RTL and testbench
================================

EEI_INITIATOR -- requirements
Module: eei_initiator

Interface
REQ-001 Parameter EEI_RS_MAX, 2, number of source operand values forwarded per request.
REQ-002 Parameter EEI_RD_MAX, 8, maximum destination values returned per request.
REQ-003 Parameter TIMEOUT, 64, cycles allowed from eei_req assertion to eei_ack before abort (min 2).
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 issue_valid/issue_ready  in/out  1/1  decoded custom instruction handshake.
REQ-007 issue_ext, issue_funct3, issue_funct7  in  1/3/7  instruction fields.
REQ-008 issue_rd, issue_batch_start, issue_batch_len  in  5/5/5  single rd index, batch base register, batch length.
REQ-009 issue_rs_val[EEI_RS_MAX-1:0]  in  32 each  operand values.
REQ-010 eei_req, eei_ext, eei_funct3, eei_funct7, eei_batch_start, eei_batch_len, eei_rs_val[]  out  EEI request bundle, widths as issue_*.
REQ-011 eei_ack, eei_error  in  1/1  responder completion and error.
REQ-012 eei_rd_op  in  2  0 no write, 1 single rd, 2 batch, 3 reserved.
REQ-013 eei_rd_len  in  5  batch write count; eei_rd_val[EEI_RD_MAX-1:0]  in  32 each.
REQ-014 rf_we, rf_waddr, rf_wdata  out  1/5/32  register-file write port.
REQ-015 done_valid, done_error  out  1/1  one-cycle completion pulse and fault flag.

Function
REQ-016 FSM states IDLE, WAIT, BATCH; issue_ready shall be 1 only in IDLE.
REQ-017 IDLE: on issue_valid&issue_ready, all issue_* fields shall be latched and state WAIT entered; eei_req=1 from the next cycle.
REQ-018 WAIT: eei_req and every request field shall stay high/stable until the cycle eei_ack=1 is sampled, inclusive.
REQ-019 Ack with eei_error=1, or eei_rd_op=3: no rf writes; next cycle done_valid=1, done_error=1, return IDLE.
REQ-020 Ack, rd_op=0: next cycle done_valid=1, done_error=0, IDLE.
REQ-021 Ack, rd_op=1: next cycle rf_we=1, rf_waddr=latched rd, rf_wdata=eei_rd_val[0] captured at ack, done_valid=1 same cycle, IDLE.
REQ-022 Ack, rd_op=2: capture L=min(eei_rd_len,EEI_RD_MAX) and eei_rd_val[0..L-1], enter BATCH; L=0 behaves as rd_op=0.
REQ-023 BATCH: write k=0..L-1 on consecutive cycles, rf_waddr=(batch_start+k) mod 32, rf_wdata=captured value k; done_valid asserted with the last write, then IDLE.
REQ-024 Any write whose address is 0 shall have rf_we=0 but still consume its cycle.
REQ-025 eei_req shall drop the cycle after ack; a new request needs at least one IDLE cycle.
REQ-026 Timeout: counter in WAIT; if TIMEOUT cycles pass without ack, eei_req drops, done_valid=1, done_error=1 next cycle, IDLE.
REQ-027 An ack in the same cycle as timeout expiry shall win (normal completion).
REQ-028 eei_ack outside WAIT shall be ignored.

Reset
REQ-029 Async reset: state IDLE, eei_req=0, rf_we=0, done_valid=0, done_error=0, counters and captured data 0.
REQ-030 Reset mid-WAIT or mid-BATCH aborts immediately; no further rf writes, no done pulse.

Structure
REQ-031 Package eei_pkg holds the state enum, rd_op encodings (EEI_RD_NONE/SINGLE/BATCH/RSVD) and field widths, shared with the responder side.
REQ-032 Single module; no sub-module. Result buffer is EEI_RD_MAX x 32 flops.

Verification
REQ-033 Combinational responder, ack in first req cycle, rd_op=1, rd=5, val=0xDEADBEEF -> one write x5=0xDEADBEEF, done_valid, error=0, issue-to-done 3 cycles.
REQ-034 Batch start=30, len=4, vals 1..4 -> writes x30=1, x31=2, x0 suppressed, x1=4 on 4 consecutive cycles; done with last.
REQ-035 Ack delayed 10 cycles with eei_rs_val changing upstream -> eei_req and fields stable all 10 cycles.
REQ-036 TIMEOUT=8, never ack -> eei_req drops after 8 cycles, done_error=1, no rf_we.
REQ-037 eei_error=1 with rd_op=2 -> no writes, done_error=1; rd_len=20 with RD_MAX=8 -> exactly 8 writes.
REQ-038 rst_ni low during BATCH write 2 of 4 -> rf_we=0 immediately, IDLE, issue_ready=1 after release.

Source files
------------

// File: rtl/eei_pkg.sv
// eei_pkg: shared EEI widths, FSM state codes, rd_op encodings and batch length clamp
package eei_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int F3_W = 3;
  localparam int F7_W = 7;
  localparam int LEN_W = 5;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_BATCH = 2'd2;
  typedef logic [1:0] rd_op_t;
  localparam rd_op_t EEI_RD_NONE = 2'd0;
  localparam rd_op_t EEI_RD_SINGLE = 2'd1;
  localparam rd_op_t EEI_RD_BATCH = 2'd2;
  localparam rd_op_t EEI_RD_RSVD = 2'd3;
  function automatic logic [LEN_W:0] clamp_len(input logic [LEN_W-1:0] len, input int max);
    return ({1'b0, len} > (LEN_W+1)'(max)) ? (LEN_W+1)'(max) : {1'b0, len};
  endfunction
endpackage

// File: rtl/eei_initiator_if.sv
// eei_initiator_if: issue handshake, EEI request/response bundle, rf write port and done pulse; master = initiator, slave = issuer/responder/rf side
interface eei_initiator_if #(parameter int EEI_RS_MAX = 2, parameter int EEI_RD_MAX = 8) ();
  import eei_pkg::*;
  logic issue_valid;
  logic issue_ready;
  logic issue_ext;
  logic [F3_W-1:0] issue_funct3;
  logic [F7_W-1:0] issue_funct7;
  logic [REG_W-1:0] issue_rd;
  logic [REG_W-1:0] issue_batch_start;
  logic [LEN_W-1:0] issue_batch_len;
  logic [XLEN-1:0] issue_rs_val [EEI_RS_MAX];
  logic eei_req;
  logic eei_ext;
  logic [F3_W-1:0] eei_funct3;
  logic [F7_W-1:0] eei_funct7;
  logic [REG_W-1:0] eei_batch_start;
  logic [LEN_W-1:0] eei_batch_len;
  logic [XLEN-1:0] eei_rs_val [EEI_RS_MAX];
  logic eei_ack;
  logic eei_error;
  logic [1:0] eei_rd_op;
  logic [LEN_W-1:0] eei_rd_len;
  logic [XLEN-1:0] eei_rd_val [EEI_RD_MAX];
  logic rf_we;
  logic [REG_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic done_valid;
  logic done_error;
  modport master (
    input issue_valid, issue_ext, issue_funct3, issue_funct7, issue_rd, issue_batch_start, issue_batch_len, issue_rs_val,
    input eei_ack, eei_error, eei_rd_op, eei_rd_len, eei_rd_val,
    output issue_ready, eei_req, eei_ext, eei_funct3, eei_funct7, eei_batch_start, eei_batch_len, eei_rs_val,
    output rf_we, rf_waddr, rf_wdata, done_valid, done_error
  );
  modport slave (
    output issue_valid, issue_ext, issue_funct3, issue_funct7, issue_rd, issue_batch_start, issue_batch_len, issue_rs_val,
    output eei_ack, eei_error, eei_rd_op, eei_rd_len, eei_rd_val,
    input issue_ready, eei_req, eei_ext, eei_funct3, eei_funct7, eei_batch_start, eei_batch_len, eei_rs_val,
    input rf_we, rf_waddr, rf_wdata, done_valid, done_error
  );
endinterface

// File: rtl/eei_initiator.sv
// eei_initiator: issues latched custom instructions as EEI requests, waits for ack or timeout, writes single/batch results to the rf; ports clk_i, rst_ni, bus (eei_initiator_if.master)
module eei_initiator import eei_pkg::*; #(
  parameter int EEI_RS_MAX = 2,
  parameter int EEI_RD_MAX = 8,
  parameter int TIMEOUT = 64
) (
  input logic clk_i,
  input logic rst_ni,
  eei_initiator_if.master bus
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  state_t state;
  logic [REG_W-1:0] rd;
  logic [TW-1:0] timer;
  logic [REG_W-1:0] baddr;
  logic [LEN_W:0] rem;
  logic [XLEN-1:0] rbuf [EEI_RD_MAX];
  logic [LEN_W:0] len_cl;
  assign len_cl = clamp_len(bus.eei_rd_len, EEI_RD_MAX);
  assign bus.issue_ready = state == ST_IDLE;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= ST_IDLE;
      rd <= '0;
      timer <= '0;
      baddr <= '0;
      rem <= '0;
      for (int i = 0; i < EEI_RD_MAX; i++) rbuf[i] <= '0;
      for (int i = 0; i < EEI_RS_MAX; i++) bus.eei_rs_val[i] <= '0;
      bus.eei_req <= 1'b0;
      bus.eei_ext <= 1'b0;
      bus.eei_funct3 <= '0;
      bus.eei_funct7 <= '0;
      bus.eei_batch_start <= '0;
      bus.eei_batch_len <= '0;
      bus.rf_we <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.done_valid <= 1'b0;
      bus.done_error <= 1'b0;
    end else begin
      bus.rf_we <= 1'b0;
      bus.done_valid <= 1'b0;
      bus.done_error <= 1'b0;
      case (state)
        ST_IDLE: if (bus.issue_valid) begin
          state <= ST_WAIT;
          timer <= '0;
          rd <= bus.issue_rd;
          bus.eei_req <= 1'b1;
          bus.eei_ext <= bus.issue_ext;
          bus.eei_funct3 <= bus.issue_funct3;
          bus.eei_funct7 <= bus.issue_funct7;
          bus.eei_batch_start <= bus.issue_batch_start;
          bus.eei_batch_len <= bus.issue_batch_len;
          for (int i = 0; i < EEI_RS_MAX; i++) bus.eei_rs_val[i] <= bus.issue_rs_val[i];
        end
        ST_WAIT: if (bus.eei_ack) begin
          state <= ST_IDLE;
          bus.eei_req <= 1'b0;
          bus.done_valid <= 1'b1;
          if (bus.eei_error || bus.eei_rd_op == EEI_RD_RSVD) bus.done_error <= 1'b1;
          else if (bus.eei_rd_op == EEI_RD_SINGLE) begin
            bus.rf_we <= rd != '0;
            bus.rf_waddr <= rd;
            bus.rf_wdata <= bus.eei_rd_val[0];
          end else if (bus.eei_rd_op == EEI_RD_BATCH && len_cl != '0) begin
            state <= ST_BATCH;
            bus.done_valid <= 1'b0;
            rem <= len_cl;
            baddr <= bus.eei_batch_start;
            for (int i = 0; i < EEI_RD_MAX; i++) rbuf[i] <= bus.eei_rd_val[i];
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state <= ST_IDLE;
          bus.eei_req <= 1'b0;
          bus.done_valid <= 1'b1;
          bus.done_error <= 1'b1;
        end else timer <= timer + 1'b1;
        ST_BATCH: begin
          bus.rf_we <= baddr != '0;
          bus.rf_waddr <= baddr;
          bus.rf_wdata <= rbuf[0];
          for (int i = 0; i < EEI_RD_MAX - 1; i++) rbuf[i] <= rbuf[i+1];
          rbuf[EEI_RD_MAX-1] <= '0;
          baddr <= baddr + 1'b1;
          rem <= rem - 1'b1;
          bus.done_valid <= rem == 1;
          state <= (rem == 1) ? ST_IDLE : ST_BATCH;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_eei_initiator.sv
// tb_eei_initiator: directed scoreboard bench for eei_initiator (default TIMEOUT and a TIMEOUT=8 instance)
module tb_eei_initiator;
  import eei_pkg::*;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  wr_t wq[$];
  logic dq[$];
  wr_t e;
  logic ed;
  logic [31:0] exp_rs0;
  always #5 clk = ~clk;
  eei_initiator_if #(.EEI_RS_MAX(2), .EEI_RD_MAX(8)) bus ();
  eei_initiator_if #(.EEI_RS_MAX(2), .EEI_RD_MAX(8)) bus2 ();
  eei_initiator #(.EEI_RS_MAX(2), .EEI_RD_MAX(8), .TIMEOUT(64)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  eei_initiator #(.EEI_RS_MAX(2), .EEI_RD_MAX(8), .TIMEOUT(8)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (bus.rf_we) begin
      chk("wr_pending", 64'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("wr_addr", 64'(bus.rf_waddr), 64'(e.a));
        chk("wr_data", 64'(bus.rf_wdata), 64'(e.d));
      end
    end
    if (bus.done_valid) begin
      chk("done_pending", 64'(dq.size() != 0), 1);
      if (dq.size() != 0) begin
        ed = dq.pop_front();
        chk("done_err", 64'(bus.done_error), 64'(ed));
      end
    end
  end

  task automatic issue(input logic [4:0] rd, input logic [4:0] bs, input logic [4:0] bl);
    @(negedge clk);
    chk("issue_ready", 64'(bus.issue_ready), 1);
    exp_rs0 = 32'hA000_0000 | 32'(rd);
    bus.issue_valid = 1'b1;
    bus.issue_ext = 1'b1;
    bus.issue_funct3 = rd[2:0];
    bus.issue_funct7 = 7'h5A;
    bus.issue_rd = rd;
    bus.issue_batch_start = bs;
    bus.issue_batch_len = bl;
    bus.issue_rs_val[0] = exp_rs0;
    bus.issue_rs_val[1] = 32'h5555_0000;
    @(negedge clk);
    bus.issue_valid = 1'b0;
  endtask

  task automatic resp(input int dly, input logic [1:0] op, input logic err, input logic [4:0] len, input logic [31:0] base);
    int w = 0;
    while (!bus.eei_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_seen", 64'(bus.eei_req), 1);
    for (int c = 0; c < dly; c++) begin
      bus.issue_rs_val[0] = $urandom;
      bus.issue_funct7 = 7'(c);
      @(negedge clk);
      chk("hold_req", 64'(bus.eei_req), 1);
      chk("hold_rs0", 64'(bus.eei_rs_val[0]), 64'(exp_rs0));
      chk("hold_f7", 64'(bus.eei_funct7), 64'h5A);
    end
    bus.eei_ack = 1'b1;
    bus.eei_rd_op = op;
    bus.eei_error = err;
    bus.eei_rd_len = len;
    for (int i = 0; i < 8; i++) bus.eei_rd_val[i] = base + 32'(i);
    @(negedge clk);
    bus.eei_ack = 1'b0;
    bus.eei_error = 1'b0;
    bus.eei_rd_op = 2'd0;
  endtask

  task automatic issue2(input logic [4:0] rd);
    @(negedge clk);
    bus2.issue_valid = 1'b1;
    bus2.issue_rd = rd;
    @(negedge clk);
    bus2.issue_valid = 1'b0;
  endtask

  initial begin
    bus.issue_valid = 0; bus.issue_ext = 0; bus.issue_funct3 = 0; bus.issue_funct7 = 0;
    bus.issue_rd = 0; bus.issue_batch_start = 0; bus.issue_batch_len = 0;
    bus.eei_ack = 0; bus.eei_error = 0; bus.eei_rd_op = 0; bus.eei_rd_len = 0;
    bus2.issue_valid = 0; bus2.issue_ext = 0; bus2.issue_funct3 = 0; bus2.issue_funct7 = 0;
    bus2.issue_rd = 0; bus2.issue_batch_start = 0; bus2.issue_batch_len = 0;
    bus2.eei_ack = 0; bus2.eei_error = 0; bus2.eei_rd_op = 0; bus2.eei_rd_len = 0;
    for (int i = 0; i < 2; i++) begin bus.issue_rs_val[i] = 0; bus2.issue_rs_val[i] = 0; end
    for (int i = 0; i < 8; i++) begin bus.eei_rd_val[i] = 0; bus2.eei_rd_val[i] = 0; end
    #12;
    chk("rst_ready", 64'(bus.issue_ready), 1);
    chk("rst_req", 64'(bus.eei_req), 0);
    chk("rst_we", 64'(bus.rf_we), 0);
    chk("rst_done", 64'(bus.done_valid), 0);
    chk("rst_derr", 64'(bus.done_error), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // single write, combinational-style ack
    wq.push_back('{5'd5, 32'hDEADBEEF});
    dq.push_back(1'b0);
    issue(5'd5, 5'd0, 5'd0);
    chk("req_first", 64'(bus.eei_req), 1);
    chk("busy_not_ready", 64'(bus.issue_ready), 0);
    chk("fwd_rs0", 64'(bus.eei_rs_val[0]), 64'(exp_rs0));
    chk("fwd_f7", 64'(bus.eei_funct7), 64'h5A);
    resp(0, EEI_RD_SINGLE, 1'b0, 5'd0, 32'hDEADBEEF);
    chk("single_done", 64'(bus.done_valid), 1);
    chk("single_we", 64'(bus.rf_we), 1);
    chk("req_dropped", 64'(bus.eei_req), 0);
    // batch wrapping through x0
    wq.push_back('{5'd30, 32'd1});
    wq.push_back('{5'd31, 32'd2});
    wq.push_back('{5'd1, 32'd4});
    dq.push_back(1'b0);
    issue(5'd0, 5'd30, 5'd4);
    resp(0, EEI_RD_BATCH, 1'b0, 5'd4, 32'd1);
    chk("batch_wait", 64'(bus.rf_we), 0);
    repeat (3) @(negedge clk);
    chk("x0_we", 64'(bus.rf_we), 0);
    chk("x0_addr", 64'(bus.rf_waddr), 0);
    chk("x0_no_done", 64'(bus.done_valid), 0);
    @(negedge clk);
    chk("batch_done_last", 64'(bus.done_valid), 1);
    // delayed ack with upstream churn
    dq.push_back(1'b0);
    issue(5'd9, 5'd0, 5'd0);
    resp(10, EEI_RD_NONE, 1'b0, 5'd0, 32'd0);
    chk("none_done", 64'(bus.done_valid), 1);
    // error beats batch
    dq.push_back(1'b1);
    issue(5'd2, 5'd10, 5'd4);
    resp(0, EEI_RD_BATCH, 1'b1, 5'd4, 32'd7);
    chk("err_done", 64'(bus.done_error), 1);
    chk("err_no_we", 64'(bus.rf_we), 0);
    // reserved rd_op
    dq.push_back(1'b1);
    issue(5'd3, 5'd0, 5'd0);
    resp(0, EEI_RD_RSVD, 1'b0, 5'd0, 32'd9);
    chk("rsvd_no_we", 64'(bus.rf_we), 0);
    // batch length clamp
    for (int i = 0; i < 8; i++) wq.push_back('{5'(8 + i), 32'(100 + i)});
    dq.push_back(1'b0);
    issue(5'd0, 5'd8, 5'd20);
    resp(0, EEI_RD_BATCH, 1'b0, 5'd20, 32'd100);
    repeat (9) @(negedge clk);
    chk("clamp_wq_empty", 64'(wq.size()), 0);
    // batch len 0 acts as no write
    dq.push_back(1'b0);
    issue(5'd4, 5'd4, 5'd0);
    resp(0, EEI_RD_BATCH, 1'b0, 5'd0, 32'd0);
    chk("len0_done", 64'(bus.done_valid), 1);
    // ack outside WAIT ignored
    @(negedge clk);
    bus.eei_ack = 1'b1;
    bus.eei_rd_op = EEI_RD_SINGLE;
    repeat (3) @(negedge clk);
    chk("idle_ack_done", 64'(bus.done_valid), 0);
    chk("idle_ack_ready", 64'(bus.issue_ready), 1);
    bus.eei_ack = 1'b0;
    bus.eei_rd_op = 2'd0;
    // timeout on TIMEOUT=8 instance
    issue2(5'd6);
    for (int c = 0; c < 8; c++) begin
      chk("to_req_high", 64'(bus2.eei_req), 1);
      chk("to_no_we", 64'(bus2.rf_we), 0);
      @(negedge clk);
    end
    chk("to_req_drop", 64'(bus2.eei_req), 0);
    chk("to_done", 64'(bus2.done_valid), 1);
    chk("to_derr", 64'(bus2.done_error), 1);
    chk("to_we", 64'(bus2.rf_we), 0);
    // ack on the expiry cycle wins
    issue2(5'd3);
    repeat (7) @(negedge clk);
    chk("edge_req", 64'(bus2.eei_req), 1);
    bus2.eei_ack = 1'b1;
    bus2.eei_rd_op = EEI_RD_SINGLE;
    bus2.eei_rd_val[0] = 32'h1234_5678;
    @(negedge clk);
    bus2.eei_ack = 1'b0;
    bus2.eei_rd_op = 2'd0;
    chk("edge_done", 64'(bus2.done_valid), 1);
    chk("edge_derr", 64'(bus2.done_error), 0);
    chk("edge_we", 64'(bus2.rf_we), 1);
    chk("edge_waddr", 64'(bus2.rf_waddr), 3);
    chk("edge_wdata", 64'(bus2.rf_wdata), 64'h1234_5678);
    // reset during batch write 2 of 4
    wq.push_back('{5'd4, 32'd50});
    wq.push_back('{5'd5, 32'd51});
    issue(5'd0, 5'd4, 5'd4);
    resp(0, EEI_RD_BATCH, 1'b0, 5'd4, 32'd50);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 64'(bus.rf_we), 0);
    chk("rst_mid_done", 64'(bus.done_valid), 0);
    chk("rst_mid_ready", 64'(bus.issue_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_ready", 64'(bus.issue_ready), 1);
    chk("post_rst_req", 64'(bus.eei_req), 0);
    chk("wq_empty", 64'(wq.size()), 0);
    chk("dq_empty", 64'(dq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
